// File: rtl/rainbow_stream.sv
// Paces the pixel coordinate counter and turns each (x, y) into a rainbow RGB
// pixel on a two-stage ready/valid stream with start-of-frame and end-of-line markers.
module rainbow_stream #(
  parameter int WIDTH  = 1024,
  parameter int HEIGHT = 768
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic [9:0]  x_in,
  input  logic [9:0]  y_in,
  output logic        coord_en,
  output logic [23:0] out_tdata,
  output logic        out_tvalid,
  input  logic        out_tready,
  output logic        out_tuser,
  output logic        out_tlast,
  output logic        frame_done
);

  localparam logic [9:0] X_LAST = 10'(WIDTH - 1);
  localparam logic [9:0] Y_LAST = 10'(HEIGHT - 1);

  logic        adv;
  logic        v1_reg;
  logic [10:0] h_reg;
  logic        sof1_reg;
  logic        eol1_reg;
  logic        eof1_reg;
  logic        tvalid_reg;
  logic [23:0] tdata_reg;
  logic        tuser_reg;
  logic        tlast_reg;
  logic        eof2_reg;
  logic        frame_done_reg;
  logic [7:0]  f;
  logic [7:0]  g;
  logic [23:0] rgb_next;

  // One advance strobe for both stages keeps the pipeline lock-stepped under backpressure.
  assign adv      = !tvalid_reg || out_tready;
  assign coord_en = rst_n && run && adv;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_reg   <= 1'b0;
      h_reg    <= 11'd0;
      sof1_reg <= 1'b0;
      eol1_reg <= 1'b0;
      eof1_reg <= 1'b0;
    end else if (adv) begin
      v1_reg   <= coord_en;
      h_reg    <= {1'b0, x_in} + {2'b00, x_in[9:1]};
      sof1_reg <= (x_in == 10'd0) && (y_in == 10'd0);
      eol1_reg <= (x_in == X_LAST);
      eof1_reg <= (x_in == X_LAST) && (y_in == Y_LAST);
    end
  end

  assign f = h_reg[7:0];
  assign g = 8'hFF - h_reg[7:0];

  // Hue wheel: six 256-step ramps between the primary and secondary colours.
  always_comb begin
    rgb_next = 24'h000000;
    case (h_reg[10:8])
      3'd0:    rgb_next = {8'hFF, f,     8'h00};
      3'd1:    rgb_next = {g,     8'hFF, 8'h00};
      3'd2:    rgb_next = {8'h00, 8'hFF, f    };
      3'd3:    rgb_next = {8'h00, g,     8'hFF};
      3'd4:    rgb_next = {f,     8'h00, 8'hFF};
      3'd5:    rgb_next = {8'hFF, 8'h00, g    };
      default: rgb_next = 24'h000000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tvalid_reg <= 1'b0;
      tdata_reg  <= 24'h000000;
      tuser_reg  <= 1'b0;
      tlast_reg  <= 1'b0;
      eof2_reg   <= 1'b0;
    end else if (adv) begin
      tvalid_reg <= v1_reg;
      tdata_reg  <= rgb_next;
      tuser_reg  <= sof1_reg;
      tlast_reg  <= eol1_reg;
      eof2_reg   <= eof1_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_done_reg <= 1'b0;
    end else begin
      frame_done_reg <= tvalid_reg && out_tready && eof2_reg;
    end
  end

  // Markers from a bubble stage are don't-care internally, so mask them here.
  assign out_tvalid = tvalid_reg;
  assign out_tdata  = tdata_reg;
  assign out_tuser  = tuser_reg && tvalid_reg;
  assign out_tlast  = tlast_reg && tvalid_reg;
  assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_rainbow_stream.sv
// Directed bench for rainbow_stream: models the coordinate counter, scoreboards
// every handshake, and checks reset, latency, markers, stalls, run gating and wrap.
module tb_rainbow_stream;
  localparam int W = 1024;
  localparam int H = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic        out_tready = 1'b1;
  logic [9:0]  x_in = 10'd0;
  logic [9:0]  y_in = 10'd0;
  logic        coord_en;
  logic [23:0] out_tdata;
  logic        out_tvalid;
  logic        out_tuser;
  logic        out_tlast;
  logic        frame_done;

  typedef struct { int x; int y; } coord_t;
  coord_t sb[$];

  int n_cmp = 0;
  int n_err = 0;
  int hs_cnt = 0, tuser_cnt = 0, tlast_cnt = 0, fd_cnt = 0;
  bit mon = 1'b0, fd_pend = 1'b0, prev_stall = 1'b0, after_eof = 1'b0;
  logic [26:0] prev_out = '0;

  rainbow_stream #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .x_in(x_in), .y_in(y_in),
    .coord_en(coord_en), .out_tdata(out_tdata), .out_tvalid(out_tvalid),
    .out_tready(out_tready), .out_tuser(out_tuser), .out_tlast(out_tlast),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] ref_rgb(input int x);
    int h, f;
    logic [7:0] r, g, b;
    h = x + x / 2;
    f = h % 256;
    r = 8'd0; g = 8'd0; b = 8'd0;
    case (h / 256)
      0: begin r = 8'd255;       g = 8'(f);         end
      1: begin r = 8'(255 - f);  g = 8'd255;        end
      2: begin g = 8'd255;       b = 8'(f);         end
      3: begin g = 8'(255 - f);  b = 8'd255;        end
      4: begin r = 8'(f);        b = 8'd255;        end
      5: begin r = 8'd255;       b = 8'(255 - f);   end
      default: ;
    endcase
    return {r, g, b};
  endfunction

  // One clock: observe at the falling edge, then step the counter model after the rising edge.
  task automatic tick();
    bit ce, hs, stall, is_eof;
    coord_t c;
    logic [26:0] cur;
    @(negedge clk);
    ce = (coord_en === 1'b1);
    if (mon) begin
      cur    = {out_tvalid, out_tuser, out_tlast, out_tdata};
      stall  = (out_tvalid === 1'b1) && (out_tready === 1'b0);
      hs     = (out_tvalid === 1'b1) && (out_tready === 1'b1);
      is_eof = 1'b0;
      chk("frame_done", 32'(frame_done), 32'(fd_pend));
      if (frame_done === 1'b1) fd_cnt++;
      if (stall) chk("stall_coord_en", 32'(coord_en), 32'd0);
      if (prev_stall) chk("stall_hold", 32'(cur), 32'(prev_out));
      if (hs) begin
        hs_cnt++;
        if (out_tuser === 1'b1) tuser_cnt++;
        if (out_tlast === 1'b1) tlast_cnt++;
        if (sb.size() == 0) begin
          chk("pix_unexpected", 32'(sb.size()), 32'd1);
        end else begin
          c = sb.pop_front();
          chk("pix", 32'({out_tuser, out_tlast, out_tdata}),
              32'({(c.x == 0 && c.y == 0), (c.x == W - 1), ref_rgb(c.x)}));
          if (after_eof) begin
            chk("wrap_tuser", 32'(out_tuser), 32'd1);
            chk("wrap_tdata", 32'(out_tdata), 32'hFF0000);
          end
          is_eof = (c.x == W - 1) && (c.y == H - 1);
          after_eof = is_eof;
        end
      end
      fd_pend    = is_eof;
      prev_stall = stall;
      prev_out   = cur;
    end
    if (ce) sb.push_back('{int'(x_in), int'(y_in)});
    @(posedge clk);
    #1;
    if (rst_n === 1'b0) begin
      sb.delete();
      fd_pend = 1'b0;
      prev_stall = 1'b0;
      after_eof = 1'b0;
    end else if (ce) begin
      if (x_in == 10'(W - 1)) begin
        x_in = 10'd0;
        y_in = (y_in == 10'(H - 1)) ? 10'd0 : y_in + 10'd1;
      end else begin
        x_in = x_in + 10'd1;
      end
    end
  endtask

  task automatic drain();
    run = 1'b0;
    out_tready = 1'b1;
    repeat (4) tick();
  endtask

  logic [9:0]  pts  [4] = '{10'd0, 10'd170, 10'd512, 10'd1023};
  logic [23:0] cols [4] = '{24'hFF0000, 24'hFFFF00, 24'h00FFFF, 24'hFF0001};
  int tuser_snap, tlast_snap;

  initial begin
    // Reset: coord_en must stay low even with run asserted.
    rst_n = 1'b0; run = 1'b1; out_tready = 1'b1;
    #1;
    chk("rst_coord_en", 32'(coord_en), 32'd0);
    tick(); tick();
    chk("rst_tvalid", 32'(out_tvalid), 32'd0);
    chk("rst_tdata", 32'(out_tdata), 32'd0);
    chk("rst_tuser", 32'(out_tuser), 32'd0);
    chk("rst_tlast", 32'(out_tlast), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    run = 1'b0; rst_n = 1'b1; mon = 1'b1;
    tick();
    $display("reset phase done");

    // Single captured colour points and their latency.
    for (int i = 0; i < 4; i++) begin
      x_in = pts[i]; y_in = 10'd3; run = 1'b1;
      tick();
      run = 1'b0;
      chk("lat_capture_tvalid", 32'(out_tvalid), 32'd0);
      tick();
      chk("lat_out_tvalid", 32'(out_tvalid), 32'd1);
      chk("colour_tdata", 32'(out_tdata), 32'(cols[i]));
      chk("colour_tlast", 32'(out_tlast), 32'(pts[i] == 10'd1023));
      $display("colour x=%0d tdata=%06h", pts[i], out_tdata);
      tick(); tick();
    end

    // Full frame with markers and the frame_done pulse.
    drain();
    x_in = 10'd0; y_in = 10'd0;
    hs_cnt = 0; tuser_cnt = 0; tlast_cnt = 0; fd_cnt = 0;
    run = 1'b1;
    for (int i = 0; i < W * H + 20 && hs_cnt < W * H; i++) tick();
    chk("frame_hs", 32'(hs_cnt), 32'(W * H));
    tuser_snap = tuser_cnt;
    tlast_snap = tlast_cnt;
    chk("frame_tuser_cnt", 32'(tuser_snap), 32'd1);
    chk("frame_tlast_cnt", 32'(tlast_snap), 32'(H));
    chk("frame_fd_before", 32'(fd_cnt), 32'd0);
    tick();
    chk("frame_fd_pulse", 32'(fd_cnt), 32'd1);
    repeat (5) tick();
    chk("frame_fd_once", 32'(fd_cnt), 32'd1);
    $display("frame hs=%0d tuser=%0d tlast=%0d", hs_cnt, tuser_snap, tlast_snap);

    // Run gating mid-line.
    drain();
    x_in = 10'd90; y_in = 10'd2; run = 1'b1;
    for (int i = 0; i < 50 && x_in != 10'd100; i++) tick();
    chk("gate_reach_x", 32'(x_in), 32'd100);
    run = 1'b0; hs_cnt = 0;
    repeat (6) tick();
    chk("gate_drain_cnt", 32'(hs_cnt), 32'd2);
    chk("gate_tvalid", 32'(out_tvalid), 32'd0);
    chk("gate_hold_x", 32'(x_in), 32'd100);
    run = 1'b1;
    tick(); tick();
    chk("gate_resume_tvalid", 32'(out_tvalid), 32'd1);
    chk("gate_resume_tdata", 32'(out_tdata), 32'(ref_rgb(100)));
    repeat (4) tick();
    $display("run gating resumed at x=100");

    // Random backpressure at about 30% ready.
    hs_cnt = 0;
    for (int i = 0; i < 40000 && hs_cnt < 5000; i++) begin
      out_tready = ($urandom_range(99) < 30);
      tick();
    end
    chk("bp_hs", 32'(hs_cnt), 32'd5000);
    drain();
    $display("backpressure pixels=%0d", hs_cnt);

    // Reset while a pixel is stalled on the output.
    run = 1'b1; out_tready = 1'b1;
    repeat (3) tick();
    out_tready = 1'b0;
    tick();
    chk("rstm_pre_tvalid", 32'(out_tvalid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstm_coord_en", 32'(coord_en), 32'd0);
    tick();
    chk("rstm_tvalid", 32'(out_tvalid), 32'd0);
    chk("rstm_tdata", 32'(out_tdata), 32'd0);
    chk("rstm_tuser", 32'(out_tuser), 32'd0);
    chk("rstm_tlast", 32'(out_tlast), 32'd0);
    chk("rstm_frame_done", 32'(frame_done), 32'd0);
    chk("rstm_coord_en_hold", 32'(coord_en), 32'd0);
    rst_n = 1'b1; run = 1'b0; out_tready = 1'b1;
    repeat (3) tick();
    chk("rstm_idle_tvalid", 32'(out_tvalid), 32'd0);
    run = 1'b1;
    repeat (5) tick();
    drain();
    $display("mid-stream reset phase done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
